riscv_trace_buffer: RTL and testbench
=====================================

# riscv_trace_buffer

Parametrised commit-trace capture unit for the RISC-V processor. It records a retired-instruction record (PC, instruction, rd, writeback data, regwrite) into an on-chip ring of DEPTH entries, then drains the records oldest-first over a valid/ready port. It sits beside the processor core: its capture inputs are driven from the core's pc_out, instruction, rd, writeData and regwrite probes, and its drain port feeds a bench monitor or debug link. It supports two capture modes, one-shot and circular, with an optional PC trigger.

## Interface
- XLEN, 64, width of PC and writeback data
- DEPTH, 16, number of trace entries; power of two, ≥2; AW = log2(DEPTH)
- clk  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high; one clock and a synchronous active-high reset
- arm  in  1  start-capture pulse; honoured only in IDLE
- mode  in  1  0 = one-shot (stop when full), 1 = circular (overwrite oldest until trigger); sampled on accepted arm
- trig_en  in  1  enable PC trigger; sampled on accepted arm
- trig_pc  in  XLEN  trigger PC; sampled on accepted arm
- force_stop  in  1  end capture immediately; honoured only in CAPTURE
- cap_valid  in  1  a retired instruction is presented this cycle
- cap_pc  in  XLEN  retired PC
- cap_instr  in  32  retired instruction
- cap_rd  in  5  destination register
- cap_wdata  in  XLEN  writeback data
- cap_regwrite  in  1  register-write enable
- out_valid  out  1  drain record available
- out_ready  in  1  consumer accepts record
- out_pc, out_instr, out_rd, out_wdata, out_regwrite  out  XLEN/32/5/XLEN/1  drain record; all zero whenever out_valid=0
- state  out  2  0 = IDLE, 1 = CAPTURE, 2 = DRAIN
- count  out  AW+1  valid entries held, range 0..DEPTH
- overflow  out  1  set when a circular capture has overwritten at least one entry

## Operation
- Storage: DEPTH × (XLEN+32+5+XLEN+1) register array. It is not reset. wr_ptr and rd_ptr are AW-bit counters that wrap modulo DEPTH.
- IDLE: out_valid=0. arm=1 moves to CAPTURE and latches mode, trig_en and trig_pc. It also clears wr_ptr, count and overflow.
- CAPTURE, on each cap_valid=1:
  - Write the record at wr_ptr, then wr_ptr+1.
  - If count<DEPTH, count+1.
  - If count==DEPTH (circular only), count stays DEPTH and overflow←1. The oldest entry is the one overwritten.
- CAPTURE exit conditions, each evaluated on the same edge as the write:
  - mode 0 and the write brings count to DEPTH → DRAIN.
  - trig_en and cap_pc==trig_pc (either mode) → DRAIN. The matching record is stored and is the newest entry.
  - force_stop=1 → DRAIN. Any concurrent cap_valid record is still written.
- arm in CAPTURE or DRAIN: ignored.
- Entering DRAIN: rd_ptr ← (wr_ptr_next − count_next) mod DEPTH, i.e. the oldest entry.
- DRAIN: out_valid = (count≠0), with out_* reading the array at rd_ptr combinationally. out_valid∧out_ready advances rd_ptr+1 and decrements count. The handshake that takes count to 0 returns the block to IDLE. If DRAIN is entered with count=0, the block returns to IDLE on the next edge.
- Records are emitted in capture order, oldest first, with no duplicates and no gaps other than overwritten entries.
- overflow holds its value through DRAIN and IDLE until the next accepted arm or reset.

## Timing
- Reset values: state=IDLE, count=0, overflow=0, wr_ptr=rd_ptr=0, out_valid=0, all out_* =0.
- Reset in any state, including mid-capture or mid-drain, takes effect on the next edge and discards buffered records.
- arm accepted at edge N: state=CAPTURE from N+1. The first record that can be captured is the one presented in cycle N+1.
- Full/trigger/force_stop at edge N: state=DRAIN and out_valid=1 from N+1. The drain latency is 1 cycle.
- One record per cycle on both capture and drain, so drain throughput is 1/cycle with out_ready held high.
- out_ready low holds out_* stable.
- count, state and overflow are registered outputs.
- Trigger comparison is a full XLEN-bit equality.

## Test plan
- Reset: reset=1 for 2 cycles with random inputs → state=0, count=0, overflow=0, out_valid=0, all out_* =0.
- One-shot, DEPTH=16: arm with mode=0, then 20 commits with PCs 0x0,0x4,…,0x4C → DRAIN after the 16th. Draining with out_ready=1 yields PCs 0x0..0x3C in order, overflow=0, then IDLE.
- Circular with trigger: arm with mode=1, trig_en=1, trig_pc=0x58, then commits with PC 0x0 step 4 → stop at 0x58 (23 commits). count=16, overflow=1, drain yields PCs 0x1C..0x58.
- Back-pressure: during drain toggle out_ready 1,0,0,1 → each record is held stable while out_ready=0, none is lost or duplicated, and count decrements only on handshakes.
- force_stop after 3 commits → DRAIN holding 3 records, which drain in order. force_stop with 0 commits → DRAIN for 1 cycle with out_valid=0, then IDLE.
- Reset at the 2nd drain handshake → IDLE, count=0. A subsequent arm captures fresh data with no stale records.

Source files
------------

// File: rtl/riscv_trace_buffer.sv
// Commit-trace capture buffer: records retired-instruction records into a ring
// in one-shot or circular mode, then drains them oldest-first over valid/ready.
module riscv_trace_buffer #(
    parameter int XLEN  = 64,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            arm,
    input  logic            mode,
    input  logic            trig_en,
    input  logic [XLEN-1:0] trig_pc,
    input  logic            force_stop,
    input  logic            cap_valid,
    input  logic [XLEN-1:0] cap_pc,
    input  logic [31:0]     cap_instr,
    input  logic [4:0]      cap_rd,
    input  logic [XLEN-1:0] cap_wdata,
    input  logic            cap_regwrite,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [31:0]     out_instr,
    output logic [4:0]      out_rd,
    output logic [XLEN-1:0] out_wdata,
    output logic            out_regwrite,
    output logic [1:0]      state,
    output logic [AW:0]     count,
    output logic            overflow
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DRAIN   = 2'd2
    } state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
        logic [4:0]      rd;
        logic [XLEN-1:0] wdata;
        logic            regwrite;
    } rec_t;

    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    state_t          st;
    rec_t            mem [DEPTH];
    rec_t            rd_rec;
    logic [AW-1:0]   wr_ptr, rd_ptr, wr_ptr_next;
    logic [AW:0]     count_next;
    logic            mode_q, trig_en_q;
    logic [XLEN-1:0] trig_pc_q;
    logic            full, full_hit, trig_hit;

    // NOTE: the record array has no reset; count and the pointers alone decide
    // which entries are meaningful, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (st == CAPTURE && cap_valid)
            mem[wr_ptr] <= {cap_pc, cap_instr, cap_rd, cap_wdata, cap_regwrite};
    end

    assign full        = (count == FULL_COUNT);
    assign wr_ptr_next = cap_valid ? wr_ptr + AW'(1) : wr_ptr;
    assign count_next  = (cap_valid && !full) ? count + (AW+1)'(1) : count;
    assign full_hit    = !mode_q && cap_valid && (count_next == FULL_COUNT);
    assign trig_hit    = trig_en_q && cap_valid && (cap_pc == trig_pc_q);

    // NOTE: all state updates use non-blocking assignments so every register
    // samples the pre-edge values computed by the continuous assignments above.
    always_ff @(posedge clk) begin
        if (reset) begin
            st        <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            mode_q    <= 1'b0;
            trig_en_q <= 1'b0;
            trig_pc_q <= '0;
        end else begin
            case (st)
                IDLE: begin
                    if (arm) begin
                        st        <= CAPTURE;
                        mode_q    <= mode;
                        trig_en_q <= trig_en;
                        trig_pc_q <= trig_pc;
                        wr_ptr    <= '0;
                        count     <= '0;
                        overflow  <= 1'b0;
                    end
                end
                CAPTURE: begin
                    wr_ptr <= wr_ptr_next;
                    count  <= count_next;
                    if (cap_valid && full)
                        overflow <= 1'b1;
                    // Oldest entry: a full ring wraps to wr_ptr_next itself.
                    if (force_stop || full_hit || trig_hit) begin
                        st     <= DRAIN;
                        rd_ptr <= wr_ptr_next - count_next[AW-1:0];
                    end
                end
                DRAIN: begin
                    if (count == '0) begin
                        st <= IDLE;
                    end else if (out_ready) begin
                        rd_ptr <= rd_ptr + AW'(1);
                        count  <= count - (AW+1)'(1);
                        if (count == (AW+1)'(1))
                            st <= IDLE;
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end

    assign state        = st;
    assign rd_rec       = mem[rd_ptr];
    assign out_valid    = (st == DRAIN) && (count != '0);
    assign out_pc       = out_valid ? rd_rec.pc       : '0;
    assign out_instr    = out_valid ? rd_rec.instr    : '0;
    assign out_rd       = out_valid ? rd_rec.rd       : '0;
    assign out_wdata    = out_valid ? rd_rec.wdata    : '0;
    assign out_regwrite = out_valid ? rd_rec.regwrite : 1'b0;

endmodule

// File: tb/tb_riscv_trace_buffer.sv
// Self-checking bench for riscv_trace_buffer: directed scenarios plus random
// rounds, scored against a queue-based model of the capture/drain rules.
module tb_riscv_trace_buffer;

    localparam int XLEN  = 64;
    localparam int DEPTH = 16;
    localparam int AW    = $clog2(DEPTH);

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            arm = 1'b0, mode = 1'b0, trig_en = 1'b0, force_stop = 1'b0;
    logic [XLEN-1:0] trig_pc = '0;
    logic            cap_valid = 1'b0, cap_regwrite = 1'b0;
    logic [XLEN-1:0] cap_pc = '0, cap_wdata = '0;
    logic [31:0]     cap_instr = '0;
    logic [4:0]      cap_rd = '0;
    logic            out_ready = 1'b0;
    logic            out_valid, out_regwrite, overflow;
    logic [XLEN-1:0] out_pc, out_wdata;
    logic [31:0]     out_instr;
    logic [4:0]      out_rd;
    logic [1:0]      state;
    logic [AW:0]     count;

    riscv_trace_buffer #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .arm(arm), .mode(mode), .trig_en(trig_en),
        .trig_pc(trig_pc), .force_stop(force_stop), .cap_valid(cap_valid),
        .cap_pc(cap_pc), .cap_instr(cap_instr), .cap_rd(cap_rd),
        .cap_wdata(cap_wdata), .cap_regwrite(cap_regwrite),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_instr(out_instr), .out_rd(out_rd), .out_wdata(out_wdata),
        .out_regwrite(out_regwrite), .state(state), .count(count),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
        logic [4:0]      rd;
        logic [XLEN-1:0] wdata;
        logic            regwrite;
    } rec_t;

    // Reference model: 0 idle, 1 capturing, 2 draining; q holds records oldest-first.
    int              m_st = 0;
    rec_t            q[$];
    logic            m_over = 1'b0, m_mode = 1'b0, m_te = 1'b0;
    logic [XLEN-1:0] m_tp = '0;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        rec_t r;
        if (reset) begin
            m_st = 0; q.delete(); m_over = 1'b0;
        end else begin
            case (m_st)
                0: if (arm) begin
                    m_st = 1; q.delete(); m_over = 1'b0;
                    m_mode = mode; m_te = trig_en; m_tp = trig_pc;
                end
                1: begin
                    if (cap_valid) begin
                        r.pc = cap_pc; r.instr = cap_instr; r.rd = cap_rd;
                        r.wdata = cap_wdata; r.regwrite = cap_regwrite;
                        q.push_back(r);
                        if (q.size() > DEPTH) begin
                            q.delete(0);
                            m_over = 1'b1;
                        end
                    end
                    if (force_stop || (cap_valid && ((!m_mode && q.size() == DEPTH) ||
                                                     (m_te && cap_pc == m_tp))))
                        m_st = 2;
                end
                2: begin
                    if (q.size() == 0) m_st = 0;
                    else if (out_ready) begin
                        q.delete(0);
                        if (q.size() == 0) m_st = 0;
                    end
                end
                default: m_st = 0;
            endcase
        end
    endtask

    task automatic compare();
        check("state", 64'(state), 64'(m_st));
        check("count", 64'(count), 64'(q.size()));
        check("overflow", 64'(overflow), 64'(m_over));
        if (m_st == 2 && q.size() > 0) begin
            check("out_valid", 64'(out_valid), 64'(1));
            check("out_pc", out_pc, q[0].pc);
            check("out_instr", 64'(out_instr), 64'(q[0].instr));
            check("out_rd", 64'(out_rd), 64'(q[0].rd));
            check("out_wdata", out_wdata, q[0].wdata);
            check("out_regwrite", 64'(out_regwrite), 64'(q[0].regwrite));
        end else begin
            check("out_valid", 64'(out_valid), 64'(0));
            check("out_zero", out_pc | out_wdata | 64'(out_instr) | 64'(out_rd) |
                  64'(out_regwrite), 64'(0));
        end
    endtask

    // Apply the currently driven inputs for one clock edge, then score outputs.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        compare();
    endtask

    task automatic rand_payload(input logic [XLEN-1:0] pc);
        cap_pc       = pc;
        cap_instr    = $urandom;
        cap_rd       = 5'($urandom);
        cap_wdata    = {$urandom, $urandom};
        cap_regwrite = 1'($urandom);
    endtask

    task automatic do_arm(input logic md, input logic te, input logic [XLEN-1:0] tp);
        arm = 1'b1; mode = md; trig_en = te; trig_pc = tp;
        tick();
        arm = 1'b0; mode = 1'($urandom); trig_en = 1'($urandom); trig_pc = {$urandom, $urandom};
    endtask

    task automatic commit(input logic [XLEN-1:0] pc, input logic fs);
        cap_valid = 1'b1; force_stop = fs;
        rand_payload(pc);
        tick();
        cap_valid = 1'b0; force_stop = 1'b0;
    endtask

    // Drain until the model returns to idle; bp selects the 1,0,0,1 ready pattern,
    // extra presents ignored commits (and stray arms) while draining.
    task automatic drain_all(input bit bp, input int extra, input logic [XLEN-1:0] xpc);
        int i;
        for (i = 0; i < 200 && m_st == 2; i++) begin
            out_ready = bp ? ((i % 4) == 0 || (i % 4) == 3) : 1'b1;
            arm = 1'($urandom);
            cap_valid = (i < extra);
            rand_payload(xpc + XLEN'(4 * i));
            tick();
        end
        arm = 1'b0; cap_valid = 1'b0; out_ready = 1'b0;
        if (i >= 200) check("drain_timeout", 64'(state), 64'(0));
    endtask

    initial begin
        int n;
        // Reset with random inputs for two cycles.
        for (int i = 0; i < 2; i++) begin
            arm = 1'($urandom); mode = 1'($urandom); trig_en = 1'($urandom);
            force_stop = 1'($urandom); cap_valid = 1'($urandom); out_ready = 1'($urandom);
            rand_payload({$urandom, $urandom});
            tick();
        end
        reset = 1'b0; arm = 1'b0; force_stop = 1'b0; cap_valid = 1'b0; out_ready = 1'b0;
        tick();

        // One-shot: 16 commits fill the ring; PCs 0x40..0x4C arrive during drain.
        do_arm(1'b0, 1'b0, '0);
        for (n = 0; n < 20 && m_st == 1; n++) commit(XLEN'(4 * n), 1'b0);
        check("oneshot_count", 64'(count), 64'(16));
        check("oneshot_state", 64'(state), 64'(2));
        check("oneshot_first_pc", out_pc, 64'h0);
        drain_all(1'b0, 4, 64'h40);

        // Circular with trigger at 0x58: 23 commits, oldest 7 overwritten.
        do_arm(1'b1, 1'b1, 64'h58);
        for (n = 0; n < 40 && m_st == 1; n++) commit(XLEN'(4 * n), 1'b0);
        check("circ_count", 64'(count), 64'(16));
        check("circ_overflow", 64'(overflow), 64'(1));
        check("circ_first_pc", out_pc, 64'h1C);
        drain_all(1'b1, 0, '0);
        check("circ_overflow_held", 64'(overflow), 64'(1));

        // force_stop on the third commit, drained with back-pressure.
        do_arm(1'b0, 1'b0, '0);
        commit(64'h100, 1'b0);
        commit(64'h104, 1'b0);
        commit(64'h108, 1'b1);
        check("fs3_count", 64'(count), 64'(3));
        drain_all(1'b1, 0, '0);

        // force_stop with no commits: one empty drain cycle, then idle.
        do_arm(1'b0, 1'b0, '0);
        force_stop = 1'b1;
        tick();
        force_stop = 1'b0;
        check("fs0_state", 64'(state), 64'(2));
        check("fs0_valid", 64'(out_valid), 64'(0));
        tick();
        check("fs0_idle", 64'(state), 64'(0));

        // Reset on the second drain handshake, then a fresh capture.
        do_arm(1'b1, 1'b0, '0);
        for (int i = 0; i < 5; i++) commit(64'h200 + XLEN'(4 * i), i == 4);
        out_ready = 1'b1;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0; out_ready = 1'b0;
        check("rst_mid_count", 64'(count), 64'(0));
        check("rst_mid_state", 64'(state), 64'(0));
        do_arm(1'b0, 1'b0, '0);
        commit(64'h300, 1'b0);
        commit(64'h304, 1'b1);
        check("fresh_first_pc", out_pc, 64'h300);
        drain_all(1'b0, 0, '0);

        // Random rounds against the model.
        for (int r = 0; r < 8; r++) begin
            do_arm(1'($urandom), 1'($urandom), XLEN'(4 * $urandom_range(0, 24)));
            for (int c = 0; c < 60 && m_st == 1; c++) begin
                cap_valid = ($urandom % 4) != 0;
                force_stop = ($urandom % 40) == 0;
                out_ready = 1'($urandom);
                rand_payload(XLEN'(4 * $urandom_range(0, 24)));
                tick();
            end
            cap_valid = 1'b0;
            force_stop = (m_st == 1);
            tick();
            force_stop = 1'b0;
            for (int c = 0; c < 200 && m_st == 2; c++) begin
                out_ready = 1'($urandom);
                cap_valid = 1'($urandom);
                rand_payload({$urandom, $urandom});
                tick();
            end
            cap_valid = 1'b0; out_ready = 1'b0;
            check("rand_idle", 64'(state), 64'(0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
